// File: rtl/iob_piso_shift_if.sv
// Handshake and serial-side signals of the parallel-in serial-out shifter.
// The master drives the parallel word and clock enable; the slave drives the serial outputs.
interface iob_piso_shift_if #(
  parameter int DATA_W = 8
);
  logic              ce_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic              serial_o;
  logic              sdata_valid_o;
  logic              done_o;
  logic              busy_o;

  modport master (
    output ce_i, data_i, valid_i,
    input  ready_o, serial_o, sdata_valid_o, done_o, busy_o
  );

  modport slave (
    input  ce_i, data_i, valid_i,
    output ready_o, serial_o, sdata_valid_o, done_o, busy_o
  );
endinterface

// File: rtl/iob_piso_shift.sv
// Parallel-in serial-out shifter: one DATA_W-bit word per valid/ready transfer, one bit per enabled cycle.
// state | meaning
// IDLE  | no word in flight, serial line at IDLE_VAL
// SHIFT | word in flight, cnt = bits still to present including the current one
module iob_piso_shift #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_VAL  = 1
) (
  input logic              clk_i,
  input logic              arst_i,
  iob_piso_shift_if.slave  bus
);
  localparam int   CNT_W    = $clog2(DATA_W + 1);
  localparam logic IDLE_BIT = IDLE_VAL[0];

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sr, sr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last;
  logic              accept;

  assign last   = (cnt == CNT_W'(1));
  assign accept = bus.valid_i & bus.ready_o & bus.ce_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A new word can only be accepted while idle or on the last bit, so accept never truncates a word
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    if (accept) begin
      state_nxt = SHIFT;
      sr_nxt    = bus.data_i;
      cnt_nxt   = CNT_W'(DATA_W);
    end else if (bus.ce_i && state == SHIFT) begin
      if (last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        sr_nxt  = (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.ready_o       = (state == IDLE) | ((state == SHIFT) & last);
    bus.sdata_valid_o = (state == SHIFT);
    bus.busy_o        = (state == SHIFT);
    bus.done_o        = (state == SHIFT) & last;
    bus.serial_o      = IDLE_BIT;
    if (state == SHIFT)
      bus.serial_o = (MSB_FIRST != 0) ? sr[DATA_W-1] : sr[0];
  end
endmodule

// File: tb/tb_iob_piso_shift.sv
// Scoreboard bench for iob_piso_shift: three instances (8-bit MSB-first, 8-bit LSB-first, 1-bit),
// expected serial bits queued per accepted word and checked by per-instance monitors.
module tb_iob_piso_shift;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   vcnt[3];
  bit   rand_ce = 0;
  logic [1:0] q [3][$];

  iob_piso_shift_if #(.DATA_W(8)) bus0 ();
  iob_piso_shift_if #(.DATA_W(8)) bus1 ();
  iob_piso_shift_if #(.DATA_W(1)) bus2 ();

  iob_piso_shift #(.DATA_W(8), .MSB_FIRST(1), .IDLE_VAL(1)) dut0 (.clk_i(clk), .arst_i(rst), .bus(bus0));
  iob_piso_shift #(.DATA_W(8), .MSB_FIRST(0), .IDLE_VAL(1)) dut1 (.clk_i(clk), .arst_i(rst), .bus(bus1));
  iob_piso_shift #(.DATA_W(1), .MSB_FIRST(1), .IDLE_VAL(1)) dut2 (.clk_i(clk), .arst_i(rst), .bus(bus2));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endfunction

  // Expected stream of one word: {done, bit} per displayed cycle
  function automatic void push_word(int k, logic [7:0] w);
    int width = (k == 2) ? 1 : 8;
    bit msb = (k != 1);
    for (int i = 0; i < width; i++) begin
      int idx = msb ? (width - 1 - i) : i;
      q[k].push_back({logic'(i == width - 1), w[idx]});
    end
  endfunction

  function automatic void mon(int k, logic ser, logic sv, logic dn, logic bs, logic rdy, logic ce);
    logic [1:0] e;
    if (sv) vcnt[k]++;
    if (q[k].size() != 0) begin
      e = q[k][0];
      chk("serial", k, ser, e[0]);
      chk("sdata_valid", k, sv, 1);
      chk("done", k, dn, e[1]);
      chk("busy", k, bs, 1);
      chk("ready", k, rdy, e[1]);
      if (ce) void'(q[k].pop_front());
    end else begin
      chk("idle_serial", k, ser, 1);
      chk("idle_valid", k, sv, 0);
      chk("idle_done", k, dn, 0);
      chk("idle_busy", k, bs, 0);
      chk("idle_ready", k, rdy, 1);
    end
  endfunction

  always @(negedge clk) if (!rst) mon(0, bus0.serial_o, bus0.sdata_valid_o, bus0.done_o, bus0.busy_o, bus0.ready_o, bus0.ce_i);
  always @(negedge clk) if (!rst) mon(1, bus1.serial_o, bus1.sdata_valid_o, bus1.done_o, bus1.busy_o, bus1.ready_o, bus1.ce_i);
  always @(negedge clk) if (!rst) mon(2, bus2.serial_o, bus2.sdata_valid_o, bus2.done_o, bus2.busy_o, bus2.ready_o, bus2.ce_i);

  always @(posedge clk) begin
    #1;
    if (rand_ce) bus0.ce_i = ($urandom_range(0, 3) != 0);
  end

  function automatic void set_in(int k, logic v, logic [7:0] w);
    case (k)
      0: begin bus0.valid_i = v; bus0.data_i = w; end
      1: begin bus1.valid_i = v; bus1.data_i = w; end
      default: begin bus2.valid_i = v; bus2.data_i = w[0]; end
    endcase
  endfunction

  function automatic logic takes(int k);
    case (k)
      0: return bus0.ready_o & bus0.ce_i & bus0.valid_i;
      1: return bus1.ready_o & bus1.ce_i & bus1.valid_i;
      default: return bus2.ready_o & bus2.ce_i & bus2.valid_i;
    endcase
  endfunction

  // Present a word and hold it until the handshake completes; returns 1 ns after the accept edge
  task automatic send(int k, logic [7:0] w);
    int n = 0;
    bit ok = 0;
    set_in(k, 1'b1, w);
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      ok = takes(k);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst%0d: got no accept expected accept within 200 cycles", k);
    end
    @(posedge clk);
    if (ok) push_word(k, w);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 9, q[0].size() + q[1].size() + q[2].size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int v0;
    rst = 1;
    bus0.ce_i = 1; bus1.ce_i = 1; bus2.ce_i = 1;
    set_in(0, 0, 0); set_in(1, 0, 0); set_in(2, 0, 0);
    #1;
    chk("rst_serial", 0, bus0.serial_o, 1);
    chk("rst_valid", 0, bus0.sdata_valid_o, 0);
    chk("rst_busy", 0, bus0.busy_o, 0);
    chk("rst_done", 0, bus0.done_o, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (5) @(posedge clk);
    #1;

    send(0, 8'hA5);
    set_in(0, 0, 0);
    wait_drain();

    send(1, 8'h01);
    send(1, 8'h80);
    set_in(1, 0, 0);
    wait_drain();

    send(2, 8'h01);
    send(2, 8'h00);
    send(2, 8'h01);
    set_in(2, 0, 0);
    wait_drain();

    v0 = vcnt[0];
    send(0, 8'hF0);
    set_in(0, 0, 0);
    @(posedge clk); #1;
    bus0.ce_i = 0;
    repeat (3) @(posedge clk);
    #1;
    bus0.ce_i = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("stall_len", 0, vcnt[0] - v0, 11);
    wait_drain();

    send(0, 8'h3C);
    set_in(0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1;
    q[0].delete(); q[1].delete(); q[2].delete();
    #1;
    chk("midrst_serial", 0, bus0.serial_o, 1);
    chk("midrst_valid", 0, bus0.sdata_valid_o, 0);
    chk("midrst_busy", 0, bus0.busy_o, 0);
    chk("midrst_done", 0, bus0.done_o, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    send(0, 8'hC3);
    set_in(0, 0, 0);
    wait_drain();

    rand_ce = 1;
    for (int i = 0; i < 150; i++) begin
      send(0, 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        set_in(0, 0, 8'($urandom));
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    set_in(0, 0, 0);
    rand_ce = 0;
    @(posedge clk); #2;
    bus0.ce_i = 1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iob_piso_shift.md
Name: iob_piso_shift

Overview:
- Parallel-in, serial-out shifter with a valid/ready input handshake.
- Serializes one DATA_W-bit word per transfer onto a single bit line, changing on the rising clock edge.
- Sits directly upstream of the negative-edge output register (iob_reg_n with DATA_W=1). That register retimes serial_o by half a cycle for pad-level serial interfaces (SPI/UART-like TX paths).

Parameters:
DATA_W, 8, word width in bits; legal range 1..64
MSB_FIRST, 1, 1 = shift out bit DATA_W-1 first; 0 = shift out bit 0 first
IDLE_VAL, 1, value of serial_o when no word is being shifted and after reset (1 bit)

Ports:
clk_i  input  1  clock; all state changes on its rising edge
arst_i  input  1  asynchronous reset, active-high
ce_i  input  1  clock enable; when low, all state is frozen and no handshake completes
data_i  input  DATA_W  parallel word to serialize
valid_i  input  1  data_i is valid
ready_o  output  1  block can accept a word this cycle
serial_o  output  1  serial bit, registered
sdata_valid_o  output  1  serial_o carries a data bit, registered
done_o  output  1  high while the last bit of a word is on serial_o, registered
busy_o  output  1  a word is being shifted, registered

Behaviour:
- Interface: one clock (clk_i); reset arst_i is asynchronous and active-high.
- Reset values: serial_o=IDLE_VAL, sdata_valid_o=0, done_o=0, busy_o=0. State=IDLE, shift register=0, bit counter=0. ready_o=1 combinationally once reset deasserts.
- Internal state: shift register (DATA_W bits) and bit counter of width $clog2(DATA_W+1).
- States:
  - IDLE: no word in flight.
  - SHIFT: word in flight; the counter holds the number of bits still to present, including the current one.
- ready_o = (state==IDLE) | (state==SHIFT & counter==1). This is combinational from registered state and does not depend on ce_i.
- Accept condition: valid_i & ready_o & ce_i at a rising edge.
- Accept behaviour: load the shift register with data_i and the counter with DATA_W. Set state=SHIFT. The first bit is driven on serial_o in the cycle after acceptance, so latency from accept edge to first bit is 1 cycle.
- Bit ordering:
  - MSB_FIRST=1: serial_o shows data_i[DATA_W-1] first, then descending.
  - MSB_FIRST=0: data_i[0] first, then ascending.
- Bit period: each bit is held for exactly one ce_i-qualified cycle. With ce_i low the current bit, the counter and all outputs hold.
- SHIFT, counter>1, ce_i high: shift one position, decrement the counter, and keep sdata_valid_o=1 and busy_o=1.
- done_o=1 exactly while counter==1, i.e. during the last bit.
- SHIFT, counter==1, ce_i high:
  - If accept: go back-to-back. The next cycle shows the first bit of the new word, with no idle gap and sdata_valid_o staying 1.
  - Else: go to IDLE. Next cycle serial_o=IDLE_VAL, sdata_valid_o=0, busy_o=0, done_o=0.
- valid_i while ready_o=0: ignored; the producer must hold data_i and valid_i until accepted.
- DATA_W=1: counter is always 1 in SHIFT, so ready_o=1 permanently. This allows one word per cycle with done_o high on every data cycle.
- Reset mid-word: the word is abandoned immediately (asynchronously). All outputs go to reset values with no partial completion, and done_o is not pulsed.
- Width rule: IDLE_VAL uses bit 0 only; wider values are truncated to 1 bit.

Test Plan:
- Reset then idle, ce_i=1, valid_i=0 for 5 cycles -> serial_o=1, sdata_valid_o=0, busy_o=0, ready_o=1 throughout.
- DATA_W=8, MSB_FIRST=1, accept 0xA5 at edge N:
  - cycles N+1..N+8 serial_o=1,0,1,0,0,1,0,1.
  - sdata_valid_o=1 during those cycles; done_o=1 only at N+8.
  - N+9 serial_o=1, busy_o=0.
- Back-to-back, MSB_FIRST=0: 0x01 followed by 0x80 with valid_i held high -> 16 consecutive data cycles.
  - Stream is 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1.
  - done_o high at cycles 8 and 16; ready_o high only at cycles 8 and 16.
- Clock-enable stall: accept 0xF0, then drive ce_i=0 for 3 cycles after bit 2.
  - serial_o holds bit 2 value 1 for 4 cycles.
  - Total word duration is 11 cycles; bit order is unchanged.
- Reset mid-word: assert arst_i asynchronously during bit 4 of 0x3C.
  - serial_o=1, sdata_valid_o=0, busy_o=0, done_o=0 immediately.
  - After release, a new word 0xC3 shifts correctly from its first bit.
- DATA_W=1: valid_i held high with data alternating 1,0,1 -> serial_o=1,0,1 on consecutive cycles, done_o=1 and ready_o=1 each cycle.
